// File: rtl/bullet_slot_arbiter_if.sv
// Bundle of the tank, bullet-mover and fire signals shared with bullet_slot_arbiter.
// master = tank/mover side, slave = arbiter side.
interface bullet_slot_arbiter_if #(
    parameter int NUM_SLOTS = 8,
    parameter int SLOT_W    = 3
);
    logic [1:0]           game_end;
    logic                 shoot1;
    logic                 shoot2;
    logic [9:0]           tank1_x;
    logic [9:0]           tank1_y;
    logic [5:0]           tank1_angle;
    logic [9:0]           tank2_x;
    logic [9:0]           tank2_y;
    logic [5:0]           tank2_angle;
    logic [NUM_SLOTS-1:0] slot_kill;
    logic                 fire_valid;
    logic [SLOT_W-1:0]    fire_slot;
    logic                 fire_owner;
    logic [9:0]           fire_x;
    logic [9:0]           fire_y;
    logic [5:0]           fire_angle;
    logic [NUM_SLOTS-1:0] slot_active;
    logic [NUM_SLOTS-1:0] slot_owner;
    logic [2:0]           count1;
    logic [2:0]           count2;

    modport master (
        output game_end, shoot1, shoot2,
        output tank1_x, tank1_y, tank1_angle, tank2_x, tank2_y, tank2_angle,
        output slot_kill,
        input  fire_valid, fire_slot, fire_owner, fire_x, fire_y, fire_angle,
        input  slot_active, slot_owner, count1, count2
    );

    modport slave (
        input  game_end, shoot1, shoot2,
        input  tank1_x, tank1_y, tank1_angle, tank2_x, tank2_y, tank2_angle,
        input  slot_kill,
        output fire_valid, fire_slot, fire_owner, fire_x, fire_y, fire_angle,
        output slot_active, slot_owner, count1, count2
    );
endinterface

// File: rtl/bullet_slot_arbiter.sv
// Shared bullet-pool scheduler: edge-detects tank shots, arbitrates round-robin, allocates slots.
// Optional per-tank shot cooldown enabled by defining SHOT_COOLDOWN_EN.
module bullet_slot_arbiter #(
    parameter int NUM_SLOTS    = 8,
    parameter int SLOT_W       = 3,
    parameter int MAX_PER_TANK = 4,
    parameter int LIFETIME     = 300,
    parameter int COOLDOWN     = 15
) (
    input logic                  frame_clk,
    input logic                  Reset,
    bullet_slot_arbiter_if.slave bus
);
    logic [1:0]           shoot, rise, elig, grant, cd_clear;
    logic [1:0]           prev_q, prev_d, pending_q, pending_d;
    logic                 rr_last_q, rr_last_d;
    logic [NUM_SLOTS-1:0] active_q, active_d, owner_q, owner_d, free_v;
    logic [9:0]           life_q [NUM_SLOTS];
    logic [9:0]           life_d [NUM_SLOTS];
    logic [2:0]           count_q [2];
    logic [2:0]           count_d [2];
    logic [4:0]           dec [2];
    logic                 any_free;
    logic [SLOT_W-1:0]    free_slot;
    logic                 fire_valid_q, fire_valid_d, fire_owner_q, fire_owner_d;
    logic [SLOT_W-1:0]    fire_slot_q, fire_slot_d;
    logic [9:0]           fire_x_q, fire_x_d, fire_y_q, fire_y_d;
    logic [5:0]           fire_angle_q, fire_angle_d;
    logic                 flush;

    assign flush = |bus.game_end;

    // Allocation looks only at occupancy at the start of the frame.
    always_comb begin
        any_free  = 1'b0;
        free_slot = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (!active_q[i] && !any_free) begin
                any_free  = 1'b1;
                free_slot = SLOT_W'(i);
            end
        end
    end

`ifdef SHOT_COOLDOWN_EN
    localparam int CD_W = $clog2(COOLDOWN + 2);
    logic [CD_W-1:0] cd_q [2];
    logic [CD_W-1:0] cd_d [2];

    always_comb begin
        for (int unsigned n = 0; n < 2; n++) begin
            cd_clear[n] = (cd_q[n] == '0);
            if (grant[n])         cd_d[n] = CD_W'(COOLDOWN);
            else if (cd_clear[n]) cd_d[n] = '0;
            else                  cd_d[n] = cd_q[n] - CD_W'(1);
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset)      cd_q <= '{default: '0};
        else if (flush) cd_q <= '{default: '0};
        else            cd_q <= cd_d;
    end
`else
    assign cd_clear = 2'b11;
`endif

    always_comb begin
        shoot  = {bus.shoot2, bus.shoot1};
        rise   = shoot & ~prev_q;
        prev_d = shoot;
        for (int unsigned n = 0; n < 2; n++) begin
            elig[n] = pending_q[n] && (count_q[n] < 3'(MAX_PER_TANK)) && any_free && cd_clear[n];
        end

        // rr_last_q = 1 means tank 2 won the last contention; only contended grants move it.
        grant     = elig;
        rr_last_d = rr_last_q;
        if (&elig) begin
            grant     = rr_last_q ? 2'b01 : 2'b10;
            rr_last_d = ~rr_last_q;
        end
        pending_d = (pending_q & elig & ~grant) | rise;

        dec = '{default: '0};
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            free_v[i]   = active_q[i] && (bus.slot_kill[i] || life_q[i] == 10'd1);
            active_d[i] = active_q[i] && !free_v[i];
            owner_d[i]  = owner_q[i];
            life_d[i]   = active_d[i] ? life_q[i] - 10'd1 : '0;
            if (free_v[i]) dec[owner_q[i]] = dec[owner_q[i]] + 5'd1;
        end

        fire_valid_d = |grant;
        fire_slot_d  = fire_slot_q;
        fire_owner_d = fire_owner_q;
        fire_x_d     = fire_x_q;
        fire_y_d     = fire_y_q;
        fire_angle_d = fire_angle_q;
        if (|grant) begin
            active_d[free_slot] = 1'b1;
            owner_d[free_slot]  = grant[1];
            life_d[free_slot]   = 10'(LIFETIME);
            fire_slot_d         = free_slot;
            fire_owner_d        = grant[1];
            fire_x_d            = grant[1] ? bus.tank2_x     : bus.tank1_x;
            fire_y_d            = grant[1] ? bus.tank2_y     : bus.tank1_y;
            fire_angle_d        = grant[1] ? bus.tank2_angle : bus.tank1_angle;
        end

        for (int unsigned n = 0; n < 2; n++) begin
            count_d[n] = 3'({2'b00, count_q[n]} + {4'b0000, grant[n]} - dec[n]);
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset || flush) begin
            prev_q       <= '0;
            pending_q    <= '0;
            rr_last_q    <= 1'b1;
            active_q     <= '0;
            owner_q      <= '0;
            life_q       <= '{default: '0};
            count_q      <= '{default: '0};
            fire_valid_q <= 1'b0;
            fire_slot_q  <= '0;
            fire_owner_q <= 1'b0;
            fire_x_q     <= '0;
            fire_y_q     <= '0;
            fire_angle_q <= '0;
        end else begin
            prev_q       <= prev_d;
            pending_q    <= pending_d;
            rr_last_q    <= rr_last_d;
            active_q     <= active_d;
            owner_q      <= owner_d;
            life_q       <= life_d;
            count_q      <= count_d;
            fire_valid_q <= fire_valid_d;
            fire_slot_q  <= fire_slot_d;
            fire_owner_q <= fire_owner_d;
            fire_x_q     <= fire_x_d;
            fire_y_q     <= fire_y_d;
            fire_angle_q <= fire_angle_d;
        end
    end

    assign bus.fire_valid  = fire_valid_q;
    assign bus.fire_slot   = fire_slot_q;
    assign bus.fire_owner  = fire_owner_q;
    assign bus.fire_x      = fire_x_q;
    assign bus.fire_y      = fire_y_q;
    assign bus.fire_angle  = fire_angle_q;
    assign bus.slot_active = active_q;
    assign bus.slot_owner  = owner_q;
    assign bus.count1      = count_q[0];
    assign bus.count2      = count_q[1];
endmodule

// File: tb/tb_bullet_slot_arbiter.sv
// Scoreboard bench for bullet_slot_arbiter; cooldown scenario built only with SHOT_COOLDOWN_EN.
module tb_bullet_slot_arbiter;
    logic frame_clk;
    logic Reset;

    bullet_slot_arbiter_if #(.NUM_SLOTS(8), .SLOT_W(3)) bus ();

    bullet_slot_arbiter #(
        .NUM_SLOTS(8), .SLOT_W(3), .MAX_PER_TANK(4), .LIFETIME(300), .COOLDOWN(15)
    ) dut (
        .frame_clk(frame_clk),
        .Reset    (Reset),
        .bus      (bus)
    );

    typedef struct packed {
        logic [2:0] slot;
        logic       owner;
        logic [9:0] x;
        logic [9:0] y;
        logic [5:0] ang;
    } fire_t;

    fire_t sb[$];
    int tests_run = 0;
    int fails     = 0;

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, fails=%0d required 0", fails);
        $fatal(1, "watchdog");
    end

    // Every launch must match the oldest outstanding expectation.
    always @(negedge frame_clk) begin
        if (!Reset && bus.fire_valid) begin
            tests_run++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_fire: got slot=%0d owner=%0d, required no fire",
                         bus.fire_slot, bus.fire_owner);
            end else begin
                fire_t e;
                fire_t a;
                e = sb.pop_front();
                a = '{slot: bus.fire_slot, owner: bus.fire_owner, x: bus.fire_x,
                      y: bus.fire_y, ang: bus.fire_angle};
                if (a !== e) begin
                    fails++;
                    $display("FAIL fire_payload: got slot=%0d owner=%0d x=%0d y=%0d ang=%0d, required slot=%0d owner=%0d x=%0d y=%0d ang=%0d",
                             a.slot, a.owner, a.x, a.y, a.ang, e.slot, e.owner, e.x, e.y, e.ang);
                end
            end
        end
    end

    function automatic logic [52:0] outs();
        return {bus.fire_valid, bus.fire_slot, bus.fire_owner, bus.fire_x, bus.fire_y,
                bus.fire_angle, bus.slot_active, bus.slot_owner, bus.count1, bus.count2};
    endfunction

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic push_fire(input int slot, input bit owner);
        fire_t e;
        e.slot  = 3'(slot);
        e.owner = owner;
        e.x     = owner ? bus.tank2_x     : bus.tank1_x;
        e.y     = owner ? bus.tank2_y     : bus.tank1_y;
        e.ang   = owner ? bus.tank2_angle : bus.tank1_angle;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        Reset        = 1'b1;
        bus.game_end = '0;
        bus.shoot1   = 1'b0;
        bus.shoot2   = 1'b0;
        bus.slot_kill = '0;
        repeat (2) tick();
        Reset = 1'b0;
        tick();
    endtask

    // One press of tank n's key; expect a launch into slot if slot >= 0.
    task automatic press(input bit owner, input int slot);
        if (owner) bus.shoot2 = 1'b1; else bus.shoot1 = 1'b1;
        if (slot >= 0) push_fire(slot, owner);
        tick();
        bus.shoot1 = 1'b0;
        bus.shoot2 = 1'b0;
        repeat (3) tick();
    endtask

    task automatic check_drained(input string name);
        repeat (2) tick();
        tests_run++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL %s_drained: %0d launches outstanding, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        #1;
        tests_run++;
        if (outs() !== '0) begin
            fails++;
            $display("FAIL reset_state: got %h, required 0", outs());
        end
        do_reset();
        press(1'b0, 0);
        bus.shoot1 = 1'b1;
        tick();
        tick();
        tests_run++;
        if (bus.fire_valid !== 1'b1) begin
            fails++;
            $display("FAIL reset_prelaunch: fire_valid=%b, required 1", bus.fire_valid);
        end
        Reset = 1'b1;
        #1;
        tests_run++;
        if (outs() !== '0) begin
            fails++;
            $display("FAIL reset_midlaunch: got %h, required 0", outs());
        end
        bus.shoot1 = 1'b0;
        tick();
        Reset = 1'b0;
        tick();
        press(1'b0, 0);
        check_drained("reset");
    endtask

    task automatic test_single();
        do_reset();
        bus.tank1_x = 10'd100; bus.tank1_y = 10'd200; bus.tank1_angle = 6'd7;
        bus.shoot1 = 1'b1;
        push_fire(0, 1'b0);
        tick();
        tests_run++;
        if (bus.fire_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_early: fire_valid=%b, required 0", bus.fire_valid);
        end
        tick();
        tests_run++;
        if (bus.fire_valid !== 1'b1) begin
            fails++;
            $display("FAIL single_latency: fire_valid=%b, required 1", bus.fire_valid);
        end
        repeat (8) tick();
        bus.shoot1 = 1'b0;
        tick();
        tests_run++;
        if ({bus.count1, bus.slot_active, bus.slot_owner} !== {3'd1, 8'h01, 8'h00}) begin
            fails++;
            $display("FAIL single_state: count1=%0d active=%h owner=%h, required 1 01 00",
                     bus.count1, bus.slot_active, bus.slot_owner);
        end
        check_drained("single");
    endtask

    task automatic test_contention();
        do_reset();
        bus.tank2_x = 10'd300; bus.tank2_y = 10'd400; bus.tank2_angle = 6'd30;
        bus.shoot1 = 1'b1; bus.shoot2 = 1'b1;
        push_fire(0, 1'b0);
        push_fire(1, 1'b1);
        repeat (3) tick();
        bus.shoot1 = 1'b0; bus.shoot2 = 1'b0;
        repeat (2) tick();
        bus.shoot1 = 1'b1; bus.shoot2 = 1'b1;
        push_fire(2, 1'b1);
        push_fire(3, 1'b0);
        repeat (4) tick();
        bus.shoot1 = 1'b0; bus.shoot2 = 1'b0;
        tick();
        tests_run++;
        if ({bus.count1, bus.count2, bus.slot_owner} !== {3'd2, 3'd2, 8'h06}) begin
            fails++;
            $display("FAIL contention_state: count1=%0d count2=%0d owner=%h, required 2 2 06",
                     bus.count1, bus.count2, bus.slot_owner);
        end
        check_drained("contention");
    endtask

    task automatic test_limit();
        do_reset();
        for (int i = 0; i < 5; i++) press(1'b0, (i < 4) ? i : -1);
        tests_run++;
        if ({bus.count1, bus.slot_active} !== {3'd4, 8'h0F}) begin
            fails++;
            $display("FAIL limit_full: count1=%0d active=%h, required 4 0f", bus.count1, bus.slot_active);
        end
        bus.slot_kill = 8'h04;
        tick();
        bus.slot_kill = '0;
        tests_run++;
        if ({bus.count1, bus.slot_active} !== {3'd3, 8'h0B}) begin
            fails++;
            $display("FAIL limit_kill: count1=%0d active=%h, required 3 0b", bus.count1, bus.slot_active);
        end
        press(1'b0, 2);
        bus.slot_kill = 8'h83;
        tick();
        bus.slot_kill = '0;
        tests_run++;
        if ({bus.count1, bus.slot_active} !== {3'd2, 8'h0C}) begin
            fails++;
            $display("FAIL limit_double_kill: count1=%0d active=%h, required 2 0c", bus.count1, bus.slot_active);
        end
        check_drained("limit");
    endtask

    task automatic run_life(input bit with_kill);
        int n;
        do_reset();
        bus.shoot1 = 1'b1;
        push_fire(0, 1'b0);
        tick();
        bus.shoot1 = 1'b0;
        tick();
        n = bus.slot_active[0] ? 1 : 0;
        for (int t = 0; t < 400; t++) begin
            if (with_kill && n == 300) bus.slot_kill = 8'h01;
            tick();
            bus.slot_kill = '0;
            if (bus.slot_active[0]) n++;
            else break;
        end
        tests_run++;
        if (n != 300 || bus.count1 !== 3'd0 || bus.slot_active !== 8'h00) begin
            fails++;
            $display("FAIL lifetime_kill%0d: frames=%0d count1=%0d active=%h, required 300 0 00",
                     with_kill, n, bus.count1, bus.slot_active);
        end
        check_drained("lifetime");
    endtask

    task automatic test_game_end();
        do_reset();
        press(1'b0, 0);
        press(1'b1, 1);
        tests_run++;
        if ({bus.count1, bus.count2} !== {3'd1, 3'd1}) begin
            fails++;
            $display("FAIL game_end_pre: count1=%0d count2=%0d, required 1 1", bus.count1, bus.count2);
        end
        bus.game_end = 2'b01;
        tick();
        bus.game_end = '0;
        tests_run++;
        if (outs() !== '0) begin
            fails++;
            $display("FAIL game_end_flush: got %h, required 0", outs());
        end
        press(1'b1, 0);
        check_drained("game_end");
    endtask

`ifdef SHOT_COOLDOWN_EN
    task automatic test_cooldown();
        do_reset();
        bus.shoot1 = 1'b1;
        push_fire(0, 1'b0);
        tick();
        tick();
        bus.shoot1 = 1'b0;
        repeat (4) tick();
        bus.shoot1 = 1'b1;
        tick();
        bus.shoot1 = 1'b0;
        tick();
        tests_run++;
        if (bus.fire_valid !== 1'b0) begin
            fails++;
            $display("FAIL cooldown_drop: fire_valid=%b, required 0", bus.fire_valid);
        end
        repeat (9) tick();
        bus.shoot1 = 1'b1;
        push_fire(1, 1'b0);
        tick();
        bus.shoot1 = 1'b0;
        tick();
        tests_run++;
        if (bus.fire_valid !== 1'b1) begin
            fails++;
            $display("FAIL cooldown_grant: fire_valid=%b, required 1", bus.fire_valid);
        end
        check_drained("cooldown");
    endtask
`endif

    initial begin
        Reset = 1'b1;
        bus.game_end = '0;
        bus.shoot1 = 1'b0; bus.shoot2 = 1'b0;
        bus.slot_kill = '0;
        bus.tank1_x = 10'd100; bus.tank1_y = 10'd200; bus.tank1_angle = 6'd7;
        bus.tank2_x = 10'd300; bus.tank2_y = 10'd400; bus.tank2_angle = 6'd30;
        test_reset();
        test_single();
        test_contention();
        test_limit();
        run_life(1'b0);
        run_life(1'b1);
        test_game_end();
`ifdef SHOT_COOLDOWN_EN
        test_cooldown();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
